// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction queue between fetch and decode.
// Holds {instr, pc} pairs and presents the oldest one to decode through a
// valid/ready handshake. A flush (taken branch, jal, jalr) or reset empties it.
// With no valid head, all data outputs are zero, so the opcode seen by the
// decoder is 7'b0000000 and the decoder selects its all-zero control word.
// Optional feature: define IFQ_BYPASS_EN for a zero-latency path from fetch
// to decode while the queue is empty.
module fetch_decode_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_instr,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_instr,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_pc_plus4,
   output logic [6:0]               out_op,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] C_ONE  = CW'(1'b1);
   localparam logic [AW-1:0] P_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] P_ONE  = AW'(1'b1);

   // Storage; contents are deliberately not reset, only pointers and count.
   logic [XLEN-1:0] r_mem_instr [DEPTH];
   logic [XLEN-1:0] r_mem_pc    [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_empty;
   logic            w_full;
   logic            w_bypass;
   logic            w_enq;
   logic            w_deq;
   logic [XLEN-1:0] w_head_instr;
   logic [XLEN-1:0] w_head_pc;

   // Handshake, bypass decision and head-of-queue output selection.
   always_comb begin
      w_empty      = (r_count == C_ZERO);
      w_full       = (r_count == C_FULL);
      w_bypass     = 1'b0;
      w_head_instr = {XLEN{1'b0}};
      w_head_pc    = {XLEN{1'b0}};
`ifdef IFQ_BYPASS_EN
      // Empty queue: hand the fetched entry straight to decode, unless the
      // pipeline is being flushed or reset this cycle.
      w_bypass     = w_empty && in_valid && !flush && !reset;
`else
      w_bypass     = 1'b0;
`endif
      in_ready     = !w_full;
      out_valid    = !w_empty || w_bypass;
      // A bypassed entry that decode takes immediately is never written.
      w_enq        = in_valid && !w_full && !(w_bypass && out_ready);
      w_deq        = !w_empty && out_ready;
      if (w_bypass) begin
         w_head_instr = in_instr;
         w_head_pc    = in_pc;
      end else if (!w_empty) begin
         w_head_instr = r_mem_instr[r_rd_ptr];
         w_head_pc    = r_mem_pc[r_rd_ptr];
      end else begin
         w_head_instr = {XLEN{1'b0}};
         w_head_pc    = {XLEN{1'b0}};
      end
      out_instr    = w_head_instr;
      out_pc       = w_head_pc;
      if (out_valid) begin
         out_pc_plus4 = w_head_pc + XLEN'(32'd4);
      end else begin
         out_pc_plus4 = {XLEN{1'b0}};
      end
      out_op       = w_head_instr[6:0];
      count        = r_count;
   end

   // Entry storage write; a write during flush/reset is harmless because the
   // pointers are cleared on the same edge and the slot is never read.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem_instr[r_wr_ptr] <= in_instr;
         r_mem_pc[r_wr_ptr]    <= in_pc;
      end
   end

   // Pointer and occupancy update; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= P_ZERO;
         r_rd_ptr <= P_ZERO;
         r_count  <= C_ZERO;
      end else if (flush) begin
         r_wr_ptr <= P_ZERO;
         r_rd_ptr <= P_ZERO;
         r_count  <= C_ZERO;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + P_ONE;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + P_ONE;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: a constant vector table for the directed
// scenarios, then stream and random phases compared against a queue model.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [XLEN-1:0] in_instr, in_pc, out_instr, out_pc, out_pc_plus4;
   logic [6:0]      out_op;
   logic [2:0]      count;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [63:0] mq[$];

   always #5 clk = ~clk;

   fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
      .out_op(out_op), .count(count)
   );

   typedef struct {
      logic        rst, fl, iv;
      logic [31:0] ins, pc;
      logic        ordy;
      logic [2:0]  cnt;
      logic        ov, ir;
      logic [6:0]  op;
      logic [31:0] epc, epc4;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] ins, input logic [31:0] p, input logic ordy);
      reset = rst; flush = fl; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
   endtask

   // One cycle checked against the queue model: outputs are predicted from
   // the model contents before the edge, then the model takes the edge.
   task automatic model_cycle(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] ins, input logic [31:0] p, input logic ordy);
      logic byp, ev, eir;
      logic [31:0] hi, hp, ep4;
      int sz;
      drive(rst, fl, iv, ins, p, ordy);
      #4;
      sz  = mq.size();
      eir = (sz != DEPTH);
      byp = BYP && (sz == 0) && iv && !fl && !rst;
      ev  = (sz != 0) || byp;
      if (byp) begin
         hi = ins; hp = p;
      end else if (sz != 0) begin
         hi = mq[0][63:32]; hp = mq[0][31:0];
      end else begin
         hi = 32'd0; hp = 32'd0;
      end
      ep4 = ev ? hp + 32'd4 : 32'd0;
      chk("m_count", {29'd0, count}, sz);
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, eir});
      chk("m_out_instr", out_instr, hi);
      chk("m_out_pc", out_pc, hp);
      chk("m_out_pc_plus4", out_pc_plus4, ep4);
      chk("m_out_op", {25'd0, out_op}, {25'd0, hi[6:0]});
      if (rst || fl) begin
         mq.delete();
      end else if (!(byp && ordy)) begin
         if (ev && ordy) void'(mq.pop_front());
         if (iv && eir) mq.push_back({ins, p});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] pc;
      // rst fl iv ins pc ordy | cnt ov ir op pc pc4  (outputs before the edge)
      tbl[0]  = '{1'b1,1'b0,1'b1,32'h00002083,32'h100,1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[1]  = '{1'b1,1'b0,1'b1,32'h00002083,32'h100,1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[2]  = '{1'b1,1'b0,1'b1,32'h00002083,32'h100,1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[3]  = '{1'b0,1'b0,1'b1,32'h00002083,32'h0,  1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[4]  = '{1'b0,1'b0,1'b1,32'h00100113,32'h4,  1'b0, 3'd1,1'b1,1'b1,7'h03,32'h0,32'h4};
      tbl[5]  = '{1'b0,1'b0,1'b1,32'h00208193,32'h8,  1'b0, 3'd2,1'b1,1'b1,7'h03,32'h0,32'h4};
      tbl[6]  = '{1'b0,1'b0,1'b1,32'h00310233,32'hC,  1'b0, 3'd3,1'b1,1'b1,7'h03,32'h0,32'h4};
      tbl[7]  = '{1'b0,1'b0,1'b1,32'hDEAD0037,32'h10, 1'b0, 3'd4,1'b1,1'b0,7'h03,32'h0,32'h4};
      tbl[8]  = '{1'b0,1'b0,1'b1,32'hDEAD0037,32'h10, 1'b1, 3'd4,1'b1,1'b0,7'h03,32'h0,32'h4};
      tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b1, 3'd3,1'b1,1'b1,7'h13,32'h4,32'h8};
      tbl[10] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b1, 3'd2,1'b1,1'b1,7'h13,32'h8,32'hC};
      tbl[11] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b1, 3'd1,1'b1,1'b1,7'h33,32'hC,32'h10};
      tbl[12] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[13] = '{1'b0,1'b0,1'b1,32'h0000006F,32'h20, 1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[14] = '{1'b0,1'b0,1'b1,32'h00000013,32'h24, 1'b1, 3'd1,1'b1,1'b1,7'h6F,32'h20,32'h24};
      tbl[15] = '{1'b0,1'b0,1'b1,32'h00000063,32'h28, 1'b0, 3'd1,1'b1,1'b1,7'h13,32'h24,32'h28};
      tbl[16] = '{1'b0,1'b0,1'b1,32'h00000067,32'h2C, 1'b0, 3'd2,1'b1,1'b1,7'h13,32'h24,32'h28};
      tbl[17] = '{1'b0,1'b1,1'b1,32'h00000003,32'h30, 1'b1, 3'd3,1'b1,1'b1,7'h13,32'h24,32'h28};
      tbl[18] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[19] = '{1'b0,1'b0,1'b1,32'h00000017,32'hFFFFFFFC,1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};
      tbl[20] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b1, 3'd1,1'b1,1'b1,7'h17,32'hFFFFFFFC,32'h0};
      tbl[21] = '{1'b0,1'b0,1'b0,32'h0,       32'h0,  1'b0, 3'd0,1'b0,1'b1,7'h00,32'h0,32'h0};

      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

`ifndef IFQ_BYPASS_EN
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].ordy);
         #4;
         chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
         chk($sformatf("v%0d_out_op", i), {25'd0, out_op}, {25'd0, tbl[i].op});
         chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].epc);
         chk($sformatf("v%0d_out_pc_plus4", i), out_pc_plus4, tbl[i].epc4);
         @(posedge clk); #1;
      end
`else
      // Empty queue, decode ready: same-cycle delivery, nothing stored.
      drive(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h40, 1'b1);
      #4;
      chk("byp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("byp_out_op", {25'd0, out_op}, 32'h13);
      chk("byp_count", {29'd0, count}, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #4;
      chk("byp_after_count", {29'd0, count}, 32'd0);
      chk("byp_after_valid", {31'd0, out_valid}, 32'd0);
      // Empty queue, decode stalled: shown now and also enqueued.
      drive(1'b0, 1'b0, 1'b1, 32'h0000006F, 32'h44, 1'b0);
      #4;
      chk("byp_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("byp_stall_op", {25'd0, out_op}, 32'h6F);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #4;
      chk("byp_stall_count", {29'd0, count}, 32'd1);
      chk("byp_stall_pc", out_pc, 32'h44);
      // Flush while empty suppresses the bypass.
      drive(1'b0, 1'b1, 1'b1, 32'h00000013, 32'h48, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 32'h00000013, 32'h4C, 1'b1);
      #4;
      chk("byp_flush_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
`endif
      mq.delete();

      // Steady stream: preload two entries, then enqueue and dequeue every cycle.
      pc = 32'h1000;
      for (int i = 0; i < 2; i++) begin
         model_cycle(1'b0, 1'b0, 1'b1, $urandom, pc, 1'b0);
         pc += 32'd4;
      end
      for (int i = 0; i < 10; i++) begin
         model_cycle(1'b0, 1'b0, 1'b1, $urandom, pc, 1'b1);
         pc += 32'd4;
      end

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         model_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 9) < 7), $urandom, $urandom,
                     ($urandom_range(0, 9) < 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
